match_list_streamer: RTL

- Downstream consumer of the assignment-search stage's final results: Valid, MatchCount, MinCost and the 240-bit Match_list.
- On a rising edge of the result-valid input it snapshots all results, then streams them over a valid/ready interface.
- Stream order: one header beat, then one beat per optimal assignment.
- Every assignment beat carries a permutation-integrity flag, so downstream logging and checking never touches the wide bus.

---
 rtl/match_list_streamer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/match_list_streamer.sv
// Snapshots the assignment-search results on a rising edge of In_Valid and
// streams a header beat followed by one beat per stored assignment over valid/ready.
module match_list_streamer #(
   parameter int N_ENTRY  = 10,
   parameter int N_WORKER = 8,
   parameter int FIELD_W  = 3
) (
   input  logic                                  CLK,
   input  logic                                  RST_n,
   input  logic                                  In_Valid,
   input  logic [3:0]                            MatchCount,
   input  logic [9:0]                            MinCost,
   input  logic [N_ENTRY*N_WORKER*FIELD_W-1:0]   Match_list,
   output logic                                  Out_valid,
   input  logic                                  Out_ready,
   output logic                                  Out_hdr,
   output logic                                  Out_last,
   output logic [3:0]                            Out_index,
   output logic [N_WORKER*FIELD_W-1:0]           Out_data,
   output logic                                  Out_perm_err,
   output logic                                  Busy,
   output logic                                  Done
);

   localparam int ENTRY_W = N_WORKER * FIELD_W;
   localparam int LIST_W  = N_ENTRY * ENTRY_W;
   localparam logic [3:0] MAX_CNT = 4'(N_ENTRY);

   typedef enum logic [1:0] {IDLE, HDR, ENT, FIN} state_t;

   state_t              state, state_nxt;
   logic                in_valid_d;
   logic                start;
   logic                capture;
   logic [3:0]          cnt_q;
   logic [3:0]          idx_q, idx_nxt;
   logic [9:0]          cost_q;
   logic [LIST_W-1:0]   list_q;
   logic [ENTRY_W-1:0]  cur_entry;
   logic                dup;
   logic                last_ent;

   assign start    = In_Valid & ~in_valid_d;
   assign last_ent = (idx_q == cnt_q - 4'd1);

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state      <= IDLE;
         in_valid_d <= 1'b0;
         idx_q      <= '0;
         cnt_q      <= '0;
         cost_q     <= '0;
         list_q     <= '0;
      end else begin
         state      <= state_nxt;
         in_valid_d <= In_Valid;
         idx_q      <= idx_nxt;
         if (capture) begin
            cnt_q  <= (MatchCount > MAX_CNT) ? MAX_CNT : MatchCount;
            cost_q <= MinCost;
            list_q <= Match_list;
         end
      end
   end

   // Integrity flag: any two job fields of the selected snapshot entry collide.
   always_comb begin
      cur_entry = '0;
      for (int e = 0; e < N_ENTRY; e++) begin
         if (idx_q == 4'(e)) cur_entry = list_q[e*ENTRY_W +: ENTRY_W];
      end
      dup = 1'b0;
      for (int i = 0; i < N_WORKER; i++) begin
         for (int j = i + 1; j < N_WORKER; j++) begin
            if (cur_entry[i*FIELD_W +: FIELD_W] == cur_entry[j*FIELD_W +: FIELD_W]) dup = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      idx_nxt      = idx_q;
      capture      = 1'b0;
      Out_valid    = 1'b0;
      Out_hdr      = 1'b0;
      Out_last     = 1'b0;
      Out_index    = '0;
      Out_data     = '0;
      Out_perm_err = 1'b0;
      Busy         = 1'b0;
      Done         = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               capture   = 1'b1;
               state_nxt = HDR;
            end
         end
         HDR: begin
            Out_valid = 1'b1;
            Out_hdr   = 1'b1;
            Out_last  = (cnt_q == 4'd0);
            Out_data  = ENTRY_W'({cnt_q, cost_q});
            Busy      = 1'b1;
            if (Out_ready) begin
               if (cnt_q == 4'd0) begin
                  state_nxt = FIN;
               end else begin
                  state_nxt = ENT;
                  idx_nxt   = '0;
               end
            end
         end
         ENT: begin
            Out_valid    = 1'b1;
            Out_index    = idx_q;
            Out_data     = cur_entry;
            Out_perm_err = dup;
            Out_last     = last_ent;
            Busy         = 1'b1;
            if (Out_ready) begin
               if (last_ent) state_nxt = FIN;
               else          idx_nxt   = idx_q + 4'd1;
            end
         end
         FIN: begin
            Busy      = 1'b1;
            Done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
